cr16_cond_eval: RTL and testbench

//  Consumer side of the ALU flag register: evaluates CR16 condition codes (Bcond/Jcond/Scond)

---
 rtl/cr16_defs.sv | 34 +++
 rtl/cr16_cond_decode.sv | 41 ++++
 rtl/cr16_cond_eval.sv | 105 ++++++++++
 tb/tb_cr16_cond_eval.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cr16_defs.sv
// Shared constants for the CR16 condition evaluator: flag bit positions,
// condition codes and FSM state encodings.
package cr16_defs;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_HI = 4'h4;
    localparam logic [3:0] COND_LS = 4'h5;
    localparam logic [3:0] COND_GT = 4'h6;
    localparam logic [3:0] COND_LE = 4'h7;
    localparam logic [3:0] COND_FS = 4'h8;
    localparam logic [3:0] COND_FC = 4'h9;
    localparam logic [3:0] COND_LO = 4'hA;
    localparam logic [3:0] COND_HS = 4'hB;
    localparam logic [3:0] COND_LT = 4'hC;
    localparam logic [3:0] COND_GE = 4'hD;
    localparam logic [3:0] COND_UC = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/cr16_cond_decode.sv
// Combinational CR16 condition decode: (condition code, flags) -> taken.
module cr16_cond_decode
    import cr16_defs::*;
#(
    parameter int P_FLAG_WIDTH = 5
) (
    input  logic [3:0]              cond_i,
    input  logic [P_FLAG_WIDTH-1:0] flags_i,
    output logic                    taken_o
);

    logic c, l, f, z, n;

    always_comb begin
        c = flags_i[FLAG_C];
        l = flags_i[FLAG_L];
        f = flags_i[FLAG_F];
        z = flags_i[FLAG_Z];
        n = flags_i[FLAG_N];
        taken_o = 1'b0;
        case (cond_i)
            COND_EQ: taken_o = z;
            COND_NE: taken_o = !z;
            COND_CS: taken_o = c;
            COND_CC: taken_o = !c;
            COND_HI: taken_o = l;
            COND_LS: taken_o = !l;
            COND_GT: taken_o = n;
            COND_LE: taken_o = !n;
            COND_FS: taken_o = f;
            COND_FC: taken_o = !f;
            COND_LO: taken_o = !l && !z;
            COND_HS: taken_o = l || z;
            COND_LT: taken_o = !n && !z;
            COND_GE: taken_o = n || z;
            COND_UC: taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cr16_cond_eval.sv
// CR16 condition evaluator with valid/ready request and response channels.
// Define CR16_COND_FWD_EN to forward ALU flags on a flag-write hazard instead of stalling.
module cr16_cond_eval
    import cr16_defs::*;
#(
    parameter int P_FLAG_WIDTH = 5,
    parameter int P_DATA_WIDTH = 16
) (
    input  logic                    I_CLK,
    input  logic                    I_RESET,
    input  logic                    I_REQ_VALID,
    output logic                    O_REQ_READY,
    input  logic [3:0]              I_COND,
    input  logic [P_FLAG_WIDTH-1:0] I_FLAGS,
    input  logic                    I_FLAG_WE,
    input  logic [P_FLAG_WIDTH-1:0] I_ALU_FLAGS,
    output logic                    O_RSP_VALID,
    input  logic                    I_RSP_READY,
    output logic                    O_TAKEN,
    output logic [P_DATA_WIDTH-1:0] O_SCOND_DATA,
    output logic [1:0]              O_STATE
);

    // Handshake: a request transfers on a cycle where I_REQ_VALID && O_REQ_READY;
    // a response transfers where O_RSP_VALID && I_RSP_READY, and is held until then.

    state_e                  state_q, state_d;
    logic [3:0]              cond_q, cond_d;
    logic                    taken_q, taken_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    accept, hazard, dec_taken;
    logic [3:0]              dec_cond;
    logic [P_FLAG_WIDTH-1:0] dec_flags;

    assign O_REQ_READY = !I_RESET &&
                         ((state_q == ST_IDLE) || ((state_q == ST_RESP) && I_RSP_READY));
    assign accept      = I_REQ_VALID && O_REQ_READY;
    assign hazard      = accept && I_FLAG_WE;

    // WAIT re-evaluates the latched code; a hazard sees the flags being written.
    assign dec_cond  = (state_q == ST_WAIT) ? cond_q : I_COND;
    assign dec_flags = hazard ? I_ALU_FLAGS : I_FLAGS;

    cr16_cond_decode #(
        .P_FLAG_WIDTH(P_FLAG_WIDTH)
    ) u_decode (
        .cond_i (dec_cond),
        .flags_i(dec_flags),
        .taken_o(dec_taken)
    );

    always_comb begin
        state_d = state_q;
        cond_d  = cond_q;
        taken_d = taken_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    cond_d = I_COND;
`ifdef CR16_COND_FWD_EN
                    state_d = ST_RESP;
                    taken_d = dec_taken;
`else
                    if (hazard) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_RESP;
                        taken_d = dec_taken;
                    end
`endif
                end else if ((state_q == ST_RESP) && I_RSP_READY) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!I_FLAG_WE) begin
                    state_d = ST_RESP;
                    taken_d = dec_taken;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q     <= ST_IDLE;
            cond_q      <= 4'h0;
            taken_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cond_q      <= cond_d;
            taken_q     <= taken_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign O_RSP_VALID  = rsp_valid_q;
    assign O_TAKEN      = taken_q;
    assign O_SCOND_DATA = {{(P_DATA_WIDTH-1){1'b0}}, taken_q};
    assign O_STATE      = state_q;

endmodule

// File: tb/tb_cr16_cond_eval.sv
// Self-checking bench for cr16_cond_eval against a table-level reference model.
module tb_cr16_cond_eval;
    import cr16_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  cond;
    logic [4:0]  flags, alu_flags;
    logic        flag_we;
    logic        rsp_valid, rsp_ready;
    logic        taken;
    logic [15:0] scond;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cr16_cond_eval #(.P_FLAG_WIDTH(5), .P_DATA_WIDTH(16)) dut (
        .I_CLK(clk), .I_RESET(rst), .I_REQ_VALID(req_valid), .O_REQ_READY(req_ready),
        .I_COND(cond), .I_FLAGS(flags), .I_FLAG_WE(flag_we), .I_ALU_FLAGS(alu_flags),
        .O_RSP_VALID(rsp_valid), .I_RSP_READY(rsp_ready), .O_TAKEN(taken),
        .O_SCOND_DATA(scond), .O_STATE(state)
    );

    // Codes come in pairs: the odd code of each pair is the negation of the even one.
    function automatic logic ref_taken(input logic [3:0] cc, input logic [4:0] fl);
        logic c, l, f, z, n, base;
        c = fl[0]; l = fl[1]; f = fl[2]; z = fl[3]; n = fl[4];
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = l;
            3'd3: base = n;
            3'd4: base = f;
            3'd5: base = !l && !z;
            3'd6: base = !n && !z;
            default: base = 1'b1;
        endcase
        return cc[0] ? !base : base;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; req_valid = 0; cond = 0; flags = 0; flag_we = 0; alu_flags = 0; rsp_ready = 0;
        step(); step();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
        checks++; if (taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%b exp=0", taken); end
        checks++; if (scond !== 16'h0) begin failures++; $display("FAIL reset_scond got=%h exp=0000", scond); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_hi got=%b exp=0", req_ready); end
        checks++; if (state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state, ST_IDLE); end
        rst = 0; #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_lo got=%b exp=1", req_ready); end
    endtask

    task automatic test_table();
        logic e;
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 32; f++) begin
                req_valid = 1; cond = 4'(c); flags = 5'(f); flag_we = 0;
                alu_flags = 5'($urandom); rsp_ready = 0;
                e = ref_taken(4'(c), 5'(f));
                #1;
                checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL tbl_ready c=%0d f=%0d got=%b exp=1", c, f, req_ready); end
                step();
                req_valid = 0; flags = 5'($urandom);
                checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL tbl_latency c=%0d f=%0d got=%b exp=1", c, f, rsp_valid); end
                checks++; if (taken !== e) begin failures++; $display("FAIL tbl_taken c=%0d f=%0d got=%b exp=%b", c, f, taken, e); end
                checks++; if (scond !== {15'd0, e}) begin failures++; $display("FAIL tbl_scond c=%0d f=%0d got=%h exp=%h", c, f, scond, {15'd0, e}); end
                rsp_ready = 1;
                step();
                rsp_ready = 0;
                checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL tbl_idle c=%0d f=%0d got=%b exp=0", c, f, rsp_valid); end
            end
        end
    endtask

    task automatic test_random();
        logic [0:0] exp_q[$];
        logic       prev_accept = 0, prev_stall = 0, prev_taken = 0, acc;
        logic [0:0] e;
        for (int i = 0; i < 500; i++) begin
            if (prev_accept) begin
                checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rnd_latency i=%0d got=%b exp=1", i, rsp_valid); end
            end
            if (prev_stall) begin
                checks++; if (rsp_valid !== 1'b1 || taken !== prev_taken) begin failures++; $display("FAIL rnd_hold i=%0d got=%b/%b exp=1/%b", i, rsp_valid, taken, prev_taken); end
            end
            if (i < 480) begin
                req_valid = 1'($urandom_range(0, 1));
                rsp_ready = ($urandom_range(0, 3) != 0);
            end else begin
                req_valid = 0;
                rsp_ready = 1;
            end
            cond = 4'($urandom); flags = 5'($urandom); alu_flags = 5'($urandom); flag_we = 0;
            #1;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++; $display("FAIL rnd_spurious i=%0d got=%b exp=none", i, taken);
                end else begin
                    e = exp_q.pop_front();
                    checks++; if (taken !== e[0] || scond !== {15'd0, e[0]}) begin failures++; $display("FAIL rnd_rsp i=%0d got=%b/%h exp=%b", i, taken, scond, e[0]); end
                end
            end
            acc = req_valid && req_ready;
            if (acc) exp_q.push_back(ref_taken(cond, flags));
            prev_accept = acc;
            prev_stall  = rsp_valid && !rsp_ready;
            prev_taken  = taken;
            step();
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_drain got=%0d exp=0", exp_q.size()); end
        rsp_ready = 0;
    endtask

    task automatic test_lo_stall();
        req_valid = 1; cond = COND_LO; flags = 5'b00000; flag_we = 0; rsp_ready = 0;
        step();
        req_valid = 1; cond = COND_NV; flags = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL lo_valid cyc=%0d got=%b exp=1", i, rsp_valid); end
            checks++; if (taken !== 1'b1) begin failures++; $display("FAIL lo_taken cyc=%0d got=%b exp=1", i, taken); end
            checks++; if (scond !== 16'h0001) begin failures++; $display("FAIL lo_scond cyc=%0d got=%h exp=0001", i, scond); end
            checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL lo_ready cyc=%0d got=%b exp=0", i, req_ready); end
            step();
        end
        req_valid = 0; rsp_ready = 1; #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL lo_ready_rel got=%b exp=1", req_ready); end
        step();
        rsp_ready = 0;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL lo_idle got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1; cond = COND_EQ; flags = 5'b01000; flag_we = 0; rsp_ready = 0;
        step();
        checks++; if (rsp_valid !== 1'b1 || taken !== 1'b1) begin failures++; $display("FAIL b2b_first got=%b/%b exp=1/1", rsp_valid, taken); end
        req_valid = 1; cond = COND_NE; flags = 5'b01000; rsp_ready = 1; #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", req_ready); end
        step();
        req_valid = 0;
        checks++; if (rsp_valid !== 1'b1 || taken !== 1'b0) begin failures++; $display("FAIL b2b_second got=%b/%b exp=1/0", rsp_valid, taken); end
        checks++; if (state !== ST_RESP) begin failures++; $display("FAIL b2b_state got=%0d exp=%0d", state, ST_RESP); end
        step();
        rsp_ready = 0;
        checks++; if (rsp_valid !== 1'b0 || state !== ST_IDLE) begin failures++; $display("FAIL b2b_idle got=%b/%0d exp=0/%0d", rsp_valid, state, ST_IDLE); end
    endtask

    task automatic test_hazard();
        req_valid = 1; cond = COND_EQ; flags = 5'b00000; flag_we = 1; alu_flags = 5'b01000; rsp_ready = 0;
        step();
        req_valid = 0; flag_we = 0; flags = 5'b01000; alu_flags = 5'b00000; #1;
`ifdef CR16_COND_FWD_EN
        checks++; if (rsp_valid !== 1'b1 || taken !== 1'b1) begin failures++; $display("FAIL haz_fwd got=%b/%b exp=1/1", rsp_valid, taken); end
`else
        checks++; if (rsp_valid !== 1'b0 || state !== ST_WAIT) begin failures++; $display("FAIL haz_wait got=%b/%0d exp=0/%0d", rsp_valid, state, ST_WAIT); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL haz_ready got=%b exp=0", req_ready); end
        step();
        checks++; if (rsp_valid !== 1'b1 || taken !== 1'b1) begin failures++; $display("FAIL haz_resp got=%b/%b exp=1/1", rsp_valid, taken); end
`endif
        rsp_ready = 1; step(); rsp_ready = 0;
        checks++; if (state !== ST_IDLE) begin failures++; $display("FAIL haz_idle got=%0d exp=%0d", state, ST_IDLE); end
    endtask

    task automatic test_wait_long();
        logic [4:0] fin;
        logic       e;
        req_valid = 1; cond = COND_NE; flags = 5'b00000; flag_we = 1; alu_flags = 5'b01000; rsp_ready = 0;
        step();
        req_valid = 0;
`ifdef CR16_COND_FWD_EN
        flag_we = 0;
        checks++; if (rsp_valid !== 1'b1 || taken !== 1'b0 || state !== ST_RESP) begin failures++; $display("FAIL wl_fwd got=%b/%b/%0d exp=1/0/%0d", rsp_valid, taken, state, ST_RESP); end
`else
        for (int i = 0; i < 3; i++) begin
            flags = 5'($urandom); alu_flags = 5'($urandom); #1;
            checks++; if (state !== ST_WAIT || rsp_valid !== 1'b0) begin failures++; $display("FAIL wl_wait cyc=%0d got=%0d/%b exp=%0d/0", i, state, rsp_valid, ST_WAIT); end
            step();
        end
        fin = 5'($urandom); flags = fin; flag_we = 0; e = ref_taken(COND_NE, fin);
        checks++; if (state !== ST_WAIT) begin failures++; $display("FAIL wl_last got=%0d exp=%0d", state, ST_WAIT); end
        step();
        checks++; if (rsp_valid !== 1'b1 || taken !== e) begin failures++; $display("FAIL wl_eval got=%b/%b exp=1/%b", rsp_valid, taken, e); end
`endif
        rsp_ready = 1; step(); rsp_ready = 0;
    endtask

    task automatic test_reset_mid();
        req_valid = 1; cond = COND_UC; flags = 5'($urandom); flag_we = 0; rsp_ready = 0;
        step();
        req_valid = 0;
        checks++; if (rsp_valid !== 1'b1 || taken !== 1'b1) begin failures++; $display("FAIL rm_pre got=%b/%b exp=1/1", rsp_valid, taken); end
        rst = 1; step();
        checks++; if (rsp_valid !== 1'b0 || taken !== 1'b0 || scond !== 16'h0) begin failures++; $display("FAIL rm_resp got=%b/%b/%h exp=0/0/0000", rsp_valid, taken, scond); end
        checks++; if (state !== ST_IDLE || req_ready !== 1'b0) begin failures++; $display("FAIL rm_resp_st got=%0d/%b exp=%0d/0", state, req_ready, ST_IDLE); end
        rst = 0; #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rm_rel1 got=%b exp=1", req_ready); end
        req_valid = 1; cond = COND_UC; step();
        rsp_ready = 1; req_valid = 1; cond = COND_UC; flag_we = 1; alu_flags = 5'($urandom);
        step();
        req_valid = 0; rsp_ready = 0;
`ifndef CR16_COND_FWD_EN
        checks++; if (state !== ST_WAIT || taken !== 1'b1) begin failures++; $display("FAIL rm_wait got=%0d/%b exp=%0d/1", state, taken, ST_WAIT); end
`endif
        rst = 1; step();
        checks++; if (rsp_valid !== 1'b0 || taken !== 1'b0 || scond !== 16'h0 || state !== ST_IDLE) begin failures++; $display("FAIL rm_wait_rst got=%b/%b/%h/%0d exp=0/0/0000/%0d", rsp_valid, taken, scond, state, ST_IDLE); end
        rst = 0; flag_we = 0; #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rm_rel2 got=%b exp=1", req_ready); end
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_table();
        test_random();
        test_lo_stall();
        test_back_to_back();
        test_hazard();
        test_wait_long();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
